// File: rtl/decode_stage.sv
// decode_stage: one-deep instruction decode register with an 8-entry pending
// scoreboard for read-after-write hazard stalls.
// Optional feature: define DECODE_WB_BYPASS_EN to let a same-cycle writeback
// satisfy a pending source (its data is taken from wb_data_i instead of the
// register file). Without the macro the source stalls until pending clears.
module decode_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [15:0] instr_i,
   input  logic [15:0] pc_i,
   output logic [2:0]  rs1_addr_o,
   output logic [2:0]  rs2_addr_o,
   input  logic [15:0] rs1_data_i,
   input  logic [15:0] rs2_data_i,
   input  logic        wb_en_i,
   input  logic [2:0]  wb_addr_i,
   input  logic [15:0] wb_data_i,
   input  logic        flush_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [3:0]  op_o,
   output logic [2:0]  funct_o,
   output logic [2:0]  rd_addr_o,
   output logic        regw_o,
   output logic [15:0] rs1_val_o,
   output logic [15:0] rs2_val_o,
   output logic [15:0] imm_o,
   output logic [15:0] pc_o,
   output logic        illegal_o
);

   // Raw instruction fields
   logic [3:0]  dec_op;
   logic [2:0]  dec_rd, dec_rs1, dec_rs2, dec_funct;
   logic        dec_reads1, dec_reads2, dec_writes, dec_illegal, dec_regw;
   logic [15:0] dec_imm;

   // Output register
   logic        out_valid_reg;
   logic [3:0]  op_reg;
   logic [2:0]  funct_reg, rd_reg;
   logic        regw_reg, illegal_reg;
   logic [15:0] rs1_val_reg, rs2_val_reg, imm_reg, pc_reg;

   // Scoreboard
   logic [7:0]  pending_reg, pending_next;
   logic [7:0]  pend_eff, wb_hit, set_vec, flush_clr;
   logic [15:0] op1_src, op2_src, rs1_val_next, rs2_val_next;
   logic        hazard, accept;

   assign dec_op    = instr_i[15:12];
   assign dec_rd    = instr_i[11:9];
   assign dec_rs1   = instr_i[8:6];
   assign dec_rs2   = instr_i[5:3];
   assign dec_funct = instr_i[2:0];

   assign rs1_addr_o = dec_rs1;
   assign rs2_addr_o = dec_rs2;

   // Opcode class: which sources are read, whether rd is written, immediate form
   always_comb begin
      dec_reads1  = 1'b0;
      dec_reads2  = 1'b0;
      dec_writes  = 1'b0;
      dec_illegal = 1'b0;
      dec_imm     = 16'd0;
      case (dec_op)
         4'd0: begin
            dec_reads1 = 1'b1;
            dec_reads2 = 1'b1;
            dec_writes = 1'b1;
         end
         4'd1, 4'd2: begin
            dec_reads1 = 1'b1;
            dec_writes = 1'b1;
            dec_imm    = {{10{instr_i[5]}}, instr_i[5:0]};
         end
         4'd3, 4'd4: begin
            dec_reads1 = 1'b1;
            dec_reads2 = 1'b1;
            dec_imm    = {{10{instr_i[5]}}, instr_i[5:0]};
         end
         4'd5: begin
            dec_writes = 1'b1;
            dec_imm    = {{7{instr_i[8]}}, instr_i[8:0]};
         end
         default: dec_illegal = 1'b1;
      endcase
   end

   assign dec_regw = dec_writes && (dec_rd != 3'd0);

   assign wb_hit = wb_en_i ? (8'd1 << wb_addr_i) : 8'd0;

`ifdef DECODE_WB_BYPASS_EN
   // A writeback landing this cycle resolves its register immediately
   assign pend_eff = pending_reg & ~wb_hit;
   assign op1_src  = (wb_en_i && (wb_addr_i == dec_rs1)) ? wb_data_i : rs1_data_i;
   assign op2_src  = (wb_en_i && (wb_addr_i == dec_rs2)) ? wb_data_i : rs2_data_i;
`else
   logic unused_wb_data;
   assign unused_wb_data = ^wb_data_i;
   assign pend_eff = pending_reg;
   assign op1_src  = rs1_data_i;
   assign op2_src  = rs2_data_i;
`endif

   // r0 reads as zero regardless of what the register file returns
   assign rs1_val_next = (dec_rs1 == 3'd0) ? 16'd0 : op1_src;
   assign rs2_val_next = (dec_rs2 == 3'd0) ? 16'd0 : op2_src;

   assign hazard = in_valid_i &&
                   ((dec_reads1 && (dec_rs1 != 3'd0) && pend_eff[dec_rs1]) ||
                    (dec_reads2 && (dec_rs2 != 3'd0) && pend_eff[dec_rs2]));

   assign in_ready_o = rst_n && (!out_valid_reg || out_ready_i) && !hazard && !flush_i;
   assign accept     = in_valid_i && in_ready_o;

   assign set_vec   = (accept && dec_regw) ? (8'd1 << dec_rd) : 8'd0;
   assign flush_clr = (flush_i && out_valid_reg && regw_reg) ? (8'd1 << rd_reg) : 8'd0;

   // Per-register scoreboard update: a new claim beats a same-cycle release
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_pend
         assign pending_next[gi] = (gi != 0) &&
                                   (set_vec[gi] || (pending_reg[gi] && !wb_hit[gi] && !flush_clr[gi]));
      end
   endgenerate

   // Output register and scoreboard state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_reg <= 1'b0;
         op_reg        <= 4'd0;
         funct_reg     <= 3'd0;
         rd_reg        <= 3'd0;
         regw_reg      <= 1'b0;
         rs1_val_reg   <= 16'd0;
         rs2_val_reg   <= 16'd0;
         imm_reg       <= 16'd0;
         pc_reg        <= 16'd0;
         illegal_reg   <= 1'b0;
         pending_reg   <= 8'd0;
      end else begin
         pending_reg <= pending_next;
         if (flush_i) begin
            out_valid_reg <= 1'b0;
         end else if (accept) begin
            out_valid_reg <= 1'b1;
            op_reg        <= dec_op;
            funct_reg     <= dec_funct;
            rd_reg        <= dec_rd;
            regw_reg      <= dec_regw;
            rs1_val_reg   <= rs1_val_next;
            rs2_val_reg   <= rs2_val_next;
            imm_reg       <= dec_imm;
            pc_reg        <= pc_i;
            illegal_reg   <= dec_illegal;
         end else if (out_ready_i) begin
            out_valid_reg <= 1'b0;
         end
      end
   end

   assign out_valid_o = out_valid_reg;
   assign op_o        = op_reg;
   assign funct_o     = funct_reg;
   assign rd_addr_o   = rd_reg;
   assign regw_o      = regw_reg;
   assign rs1_val_o   = rs1_val_reg;
   assign rs2_val_o   = rs2_val_reg;
   assign imm_o       = imm_reg;
   assign pc_o        = pc_reg;
   assign illegal_o   = illegal_reg;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scenarios followed by randomized traffic, all
// checked against a transaction-level reference model (register file array,
// pending set, and a one-slot output holding the last accepted decode).
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n, in_valid_i, in_ready_o;
   logic [15:0] instr_i, pc_i;
   logic [2:0]  rs1_addr_o, rs2_addr_o;
   logic [15:0] rs1_data_i, rs2_data_i;
   logic        wb_en_i;
   logic [2:0]  wb_addr_i;
   logic [15:0] wb_data_i;
   logic        flush_i, out_valid_o, out_ready_i;
   logic [3:0]  op_o;
   logic [2:0]  funct_o, rd_addr_o;
   logic        regw_o, illegal_o;
   logic [15:0] rs1_val_o, rs2_val_o, imm_o, pc_o;

   always #5 clk = ~clk;

   decode_stage dut (
      .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .instr_i(instr_i), .pc_i(pc_i), .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
      .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .wb_en_i(wb_en_i),
      .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i), .flush_i(flush_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .op_o(op_o),
      .funct_o(funct_o), .rd_addr_o(rd_addr_o), .regw_o(regw_o),
      .rs1_val_o(rs1_val_o), .rs2_val_o(rs2_val_o), .imm_o(imm_o), .pc_o(pc_o),
      .illegal_o(illegal_o)
   );

   // External register file; r0 holds junk so the zero-forcing is observable
   logic [15:0] rf [8];
   assign rs1_data_i = rf[instr_i[8:6]];
   assign rs2_data_i = rf[instr_i[5:3]];

   typedef struct packed {
      logic [3:0]  op;
      logic [2:0]  rd, rs1, rs2, funct;
      logic        r1, r2, regw, ill;
      logic [15:0] imm;
   } dec_t;

   typedef struct packed {
      logic [3:0]  op;
      logic [2:0]  funct, rd;
      logic        regw, ill;
      logic [15:0] v1, v2, imm, pc;
   } out_t;

   // Reference model state
   logic       m_valid;
   out_t       m_out;
   logic [7:0] m_pend;
   int         n_tests = 0;
   int         n_fail  = 0;
   logic       last_ready;
   logic       verbose = 1'b1;
`ifdef DECODE_WB_BYPASS_EN
   localparam logic BYPASS = 1'b1;
`else
   localparam logic BYPASS = 1'b0;
`endif

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic dec_t decode(input logic [15:0] ins);
      dec_t d;
      int   x;
      d.op    = ins[15:12];
      d.rd    = ins[11:9];
      d.rs1   = ins[8:6];
      d.rs2   = ins[5:3];
      d.funct = ins[2:0];
      d.ill   = (d.op > 4'd5);
      d.r1    = (d.op <= 4'd4);
      d.r2    = (d.op == 4'd0) || (d.op == 4'd3) || (d.op == 4'd4);
      d.regw  = ((d.op <= 4'd2) || (d.op == 4'd5)) && (d.rd != 3'd0);
      x = 0;
      if (d.op >= 4'd1 && d.op <= 4'd4) begin
         x = int'(ins[5:0]);
         if (x >= 32) x -= 64;
      end else if (d.op == 4'd5) begin
         x = int'(ins[8:0]);
         if (x >= 256) x -= 512;
      end
      d.imm = x[15:0];
      return d;
   endfunction

   function automatic logic busy(input logic [2:0] s, input logic wbe, input logic [2:0] wba);
      if (s == 3'd0) return 1'b0;
      if (BYPASS && wbe && (wba == s)) return 1'b0;
      return m_pend[s];
   endfunction

   function automatic logic [15:0] operand(input logic [2:0] s, input logic wbe,
                                           input logic [2:0] wba, input logic [15:0] wbd);
      if (s == 3'd0) return 16'd0;
      if (BYPASS && wbe && (wba == s)) return wbd;
      return rf[s];
   endfunction

   // One clock cycle: drive, compare, advance the model, commit the writeback
   task automatic step(input logic rst, input logic v, input logic [15:0] ins,
                       input logic [15:0] pc, input logic ordy, input logic wbe,
                       input logic [2:0] wba, input logic [15:0] wbd, input logic fl);
      dec_t d;
      logic haz, exp_rdy, acc;
      @(negedge clk);
      rst_n = rst; in_valid_i = v; instr_i = ins; pc_i = pc; out_ready_i = ordy;
      wb_en_i = wbe; wb_addr_i = wba; wb_data_i = wbd; flush_i = fl;
      #1;
      check_eq("out_valid", 16'(out_valid_o), 16'(m_valid));
      if (m_valid) begin
         check_eq("op",      16'(op_o),      16'(m_out.op));
         check_eq("funct",   16'(funct_o),   16'(m_out.funct));
         check_eq("rd",      16'(rd_addr_o), 16'(m_out.rd));
         check_eq("regw",    16'(regw_o),    16'(m_out.regw));
         check_eq("illegal", 16'(illegal_o), 16'(m_out.ill));
         check_eq("rs1_val", rs1_val_o, m_out.v1);
         check_eq("rs2_val", rs2_val_o, m_out.v2);
         check_eq("imm",     imm_o,     m_out.imm);
         check_eq("pc",      pc_o,      m_out.pc);
      end
      d = decode(ins);
      haz = v && ((d.r1 && busy(d.rs1, wbe, wba)) || (d.r2 && busy(d.rs2, wbe, wba)));
      exp_rdy = rst && (!m_valid || ordy) && !haz && !fl;
      check_eq("in_ready", 16'(in_ready_o), 16'(exp_rdy));
      check_eq("rs1_addr", 16'(rs1_addr_o), 16'(d.rs1));
      check_eq("rs2_addr", 16'(rs2_addr_o), 16'(d.rs2));
      last_ready = in_ready_o;
      acc = v && exp_rdy;
      if (verbose)
         $display("[TB] t=%0t rst_n=%b v=%b instr=%h wb=%b/%0d flush=%b ordy=%b -> ready=%b",
                  $time, rst, v, ins, wbe, wba, fl, ordy, in_ready_o);
      if (!rst) begin
         m_valid = 1'b0;
         m_out   = '0;
         m_pend  = 8'd0;
      end else begin
         if (wbe) m_pend[wba] = 1'b0;
         if (fl && m_valid && m_out.regw) m_pend[m_out.rd] = 1'b0;
         if (acc && d.regw) m_pend[d.rd] = 1'b1;
         if (fl) m_valid = 1'b0;
         else if (acc) begin
            m_valid = 1'b1;
            m_out.op = d.op; m_out.funct = d.funct; m_out.rd = d.rd;
            m_out.regw = d.regw; m_out.ill = d.ill; m_out.imm = d.imm; m_out.pc = pc;
            m_out.v1 = operand(d.rs1, wbe, wba, wbd);
            m_out.v2 = operand(d.rs2, wbe, wba, wbd);
         end else if (ordy) m_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      if (wbe && (wba != 3'd0)) rf[wba] = wbd;
   endtask

   task automatic idle(input logic ordy);
      step(1'b1, 1'b0, 16'h0000, 16'h0000, ordy, 1'b0, 3'd0, 16'h0000, 1'b0);
   endtask

   initial begin
      logic [31:0] r;
      logic [3:0]  op4;
      logic [2:0]  a;
      rst_n = 1'b0; in_valid_i = 1'b0; instr_i = 16'h0; pc_i = 16'h0; out_ready_i = 1'b0;
      wb_en_i = 1'b0; wb_addr_i = 3'd0; wb_data_i = 16'h0; flush_i = 1'b0;
      rf[0] = 16'hDEAD;
      for (int i = 1; i < 8; i++) rf[i] = 16'h0;
      m_valid = 1'b0; m_out = '0; m_pend = 8'd0;

      // Reset with a valid request present: must not be accepted
      step(1'b0, 1'b1, 16'h1205, 16'h0100, 1'b1, 1'b0, 3'd0, 16'h0, 1'b0);
      step(1'b0, 1'b1, 16'h1205, 16'h0100, 1'b1, 1'b0, 3'd0, 16'h0, 1'b0);
      check_eq("rst_ready", 16'(last_ready), 16'd0);
      check_eq("rst_valid", 16'(out_valid_o), 16'd0);
      check_eq("rst_fields", {op_o, funct_o, rd_addr_o, regw_o, illegal_o, 4'd0}, 16'd0);
      check_eq("rst_vals", rs1_val_o | rs2_val_o | imm_o | pc_o, 16'd0);

      // ADDI r1,r0,5 accepted immediately
      step(1'b1, 1'b1, 16'h1205, 16'h0100, 1'b1, 1'b0, 3'd0, 16'h0, 1'b0);
      check_eq("addi_ready", 16'(last_ready), 16'd1);
      check_eq("addi_valid", 16'(out_valid_o), 16'd1);
      check_eq("addi_rd", 16'(rd_addr_o), 16'd1);
      check_eq("addi_imm", imm_o, 16'd5);
      check_eq("addi_regw", 16'(regw_o), 16'd1);

      // ADD r2,r1,r1 stalls on r1, then resolves via writeback
      step(1'b1, 1'b1, 16'h0448, 16'h0102, 1'b1, 1'b0, 3'd0, 16'h0, 1'b0);
      check_eq("raw_stall", 16'(last_ready), 16'd0);
      step(1'b1, 1'b1, 16'h0448, 16'h0102, 1'b1, 1'b1, 3'd1, 16'd5, 1'b0);
      check_eq("wb_cycle_ready", 16'(last_ready), 16'(BYPASS));
      if (!BYPASS) begin
         step(1'b1, 1'b1, 16'h0448, 16'h0102, 1'b1, 1'b0, 3'd0, 16'h0, 1'b0);
         check_eq("wb_next_ready", 16'(last_ready), 16'd1);
      end
      check_eq("add_rs1", rs1_val_o, 16'd5);
      check_eq("add_rs2", rs2_val_o, 16'd5);

      // Downstream stall for 3 cycles, then release
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1, 16'h1A07, 16'h0104, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
         check_eq("stall_ready", 16'(last_ready), 16'd0);
         check_eq("stall_rd", 16'(rd_addr_o), 16'd2);
         check_eq("stall_pc", pc_o, 16'h0102);
      end
      step(1'b1, 1'b1, 16'h1A07, 16'h0104, 1'b1, 1'b0, 3'd0, 16'h0, 1'b0);
      check_eq("release_ready", 16'(last_ready), 16'd1);
      check_eq("release_rd", 16'(rd_addr_o), 16'd5);

      // Flush a held LW r3; r3 must no longer be pending
      step(1'b1, 1'b1, 16'h2601, 16'h0106, 1'b1, 1'b0, 3'd0, 16'h0, 1'b0);
      check_eq("lw_rd", 16'(rd_addr_o), 16'd3);
      step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0, 1'b1);
      check_eq("flush_valid", 16'(out_valid_o), 16'd0);
      step(1'b1, 1'b1, 16'h08C0, 16'h0108, 1'b1, 1'b0, 3'd0, 16'h0, 1'b0);
      check_eq("flush_unpend", 16'(last_ready), 16'd1);

      // Illegal opcode and writes to r0
      step(1'b1, 1'b1, 16'hFFFF, 16'h010A, 1'b1, 1'b0, 3'd0, 16'h0, 1'b0);
      check_eq("ill_flag", 16'(illegal_o), 16'd1);
      check_eq("ill_regw", 16'(regw_o), 16'd0);
      step(1'b1, 1'b1, 16'h1003, 16'h010C, 1'b1, 1'b0, 3'd0, 16'h0, 1'b0);
      check_eq("r0_regw", 16'(regw_o), 16'd0);

      // Set wins over same-cycle writeback clear on r4
      step(1'b1, 1'b1, 16'h1801, 16'h010E, 1'b1, 1'b1, 3'd4, 16'h1234, 1'b0);
      check_eq("setwin_ready", 16'(last_ready), 16'd1);
      step(1'b1, 1'b1, 16'h0D00, 16'h0110, 1'b1, 1'b0, 3'd0, 16'h0, 1'b0);
      check_eq("setwin_stall", 16'(last_ready), 16'd0);

      // Reset while the output is stalled discards it and the scoreboard
      step(1'b1, 1'b1, 16'h1E02, 16'h0112, 1'b1, 1'b0, 3'd0, 16'h0, 1'b0);
      step(1'b1, 1'b1, 16'h1E02, 16'h0114, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
      step(1'b0, 1'b1, 16'h1E02, 16'h0114, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
      check_eq("midrst_ready", 16'(last_ready), 16'd0);
      check_eq("midrst_valid", 16'(out_valid_o), 16'd0);
      idle(1'b1);
      step(1'b1, 1'b1, 16'h0D00, 16'h0116, 1'b1, 1'b0, 3'd0, 16'h0, 1'b0);
      check_eq("midrst_unpend", 16'(last_ready), 16'd1);

      // Randomized traffic
      verbose = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         r   = $urandom();
         op4 = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5));
         a   = 3'($urandom_range(0, 7));
         step(($urandom_range(0, 199) != 0),
              ($urandom_range(0, 3) != 0),
              {op4, r[11:0]},
              r[31:16],
              ($urandom_range(0, 9) < 7),
              ($urandom_range(0, 9) < 4),
              a,
              16'($urandom()),
              ($urandom_range(0, 19) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
